// File: rtl/shrx_deser.sv
// Framed serial receiver: start bit (0), WIDTH data bits MSB-first, stop bit (1) -> parallel q.
// Latency: valid rises on the en edge that samples the stop bit (WIDTH+2 en edges after start).
// Backpressure: a good frame arriving while q is still unconsumed (valid=1, ready=0) is dropped and flags ovr.
//
// Ports:
//   clk    clock, all state changes on posedge
//   rst    synchronous active-high reset, overrides everything (partial frame discarded)
//   en     bit strobe; si sampled and FSM advanced only when en=1
//   si     serial line, idles high
//   ready  downstream accept; consumes q on an edge with valid=1 (independent of en)
//   clr    clears sticky ferr/ovr (a same-edge set wins)
//   q      received data word, stable while valid=1 and ready=0
//   valid  q holds an unconsumed frame
//   busy   1 while in DATA or STOP
//   ferr   sticky framing error (stop bit sampled as 0)
//   ovr    sticky overrun (good frame dropped, holding register full)

module shrx_deser #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             si,
    input  logic             ready,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             busy,
    output logic             ferr,
    output logic             ovr
);

    // Bit counter only needs to reach WIDTH-1; keep it at least one bit wide.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] sh_q,    sh_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic             valid_q, valid_d;
    logic             busy_q,  busy_d;
    logic             ferr_q,  ferr_d;
    logic             ovr_q,   ovr_d;

    logic             load;
    logic             drop_ovr;
    logic             set_ferr;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        q_d      = q_q;
        load     = 1'b0;
        drop_ovr = 1'b0;
        set_ferr = 1'b0;

        // Handshake runs every edge regardless of en; a same-edge load re-asserts below.
        valid_d  = valid_q & ~ready;

        // Clear first so a set condition on the same edge takes priority.
        ferr_d   = ferr_q & ~clr;
        ovr_d    = ovr_q  & ~clr;

        if (en) begin
            unique case (state_q)
                IDLE: begin
                    // Any sampled 0 is taken as a start bit; no mid-bit re-check.
                    if (!si) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    // MSB-first: the first data bit ends up in sh[WIDTH-1].
                    sh_d  = {sh_q[WIDTH-2:0], si};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    state_d = IDLE;
                    if (si) begin
                        // The slot is free if empty or being consumed on this very edge.
                        if (!valid_q || ready) begin
                            load = 1'b1;
                        end else begin
                            drop_ovr = 1'b1;
                        end
                    end else begin
                        set_ferr = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (load) begin
            q_d     = sh_q;
            valid_d = 1'b1;
        end
        if (drop_ovr) begin
            ovr_d = 1'b1;
        end
        if (set_ferr) begin
            ferr_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign q     = q_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign ferr  = ferr_q;
    assign ovr   = ovr_q;

endmodule

// File: tb/tb_shrx_deser.sv
// Bench for shrx_deser: directed frame scenarios followed by randomized frames,
// every cycle compared against a queue-based frame model.
// Inputs driven 1 time unit after posedge; outputs sampled 1 time unit after posedge.

module tb_shrx_deser;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic         si;
    logic         ready;
    logic         clr;
    logic [W-1:0] q;
    logic         valid;
    logic         busy;
    logic         ferr;
    logic         ovr;

    int tests;
    int fails;
    int vcount;

    // Reference model state: frame is collected as a list of sampled bits.
    logic [W-1:0] m_q;
    logic         m_valid;
    logic         m_ferr;
    logic         m_ovr;
    logic         m_inframe;
    logic         m_bits[$];

    shrx_deser #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .si    (si),
        .ready (ready),
        .clr   (clr),
        .q     (q),
        .valid (valid),
        .busy  (busy),
        .ferr  (ferr),
        .ovr   (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Applies one clock edge worth of the frame rules to the model, using the
    // inputs as they stood on that edge.
    task automatic model_edge();
        logic         pv;
        logic [W-1:0] data;
        if (rst) begin
            m_q = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
            m_inframe = 1'b0; m_bits.delete();
            return;
        end
        pv = m_valid;
        if (m_valid && ready) m_valid = 1'b0;
        if (clr) begin
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end
        if (en) begin
            if (!m_inframe) begin
                if (!si) begin
                    m_inframe = 1'b1;
                    m_bits.delete();
                end
            end else begin
                m_bits.push_back(si);
                if (m_bits.size() == W + 1) begin
                    data = '0;
                    for (int i = 0; i < W; i++) data[W-1-i] = m_bits[i];
                    if (m_bits[W]) begin
                        if (!pv || ready) begin
                            m_q     = data;
                            m_valid = 1'b1;
                        end else begin
                            m_ovr = 1'b1;
                        end
                    end else begin
                        m_ferr = 1'b1;
                    end
                    m_inframe = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (valid === 1'b1) vcount++;
        chk("model_q",     32'(q),     32'(m_q));
        chk("model_valid", 32'(valid), 32'(m_valid));
        chk("model_busy",  32'(busy),  32'(m_inframe));
        chk("model_ferr",  32'(ferr),  32'(m_ferr));
        chk("model_ovr",   32'(ovr),   32'(m_ovr));
    endtask

    // Sends start, data MSB-first, stop. With toggle_en each bit takes an
    // en=1 cycle followed by an en=0 cycle carrying line noise.
    task automatic send_frame(input logic [W-1:0] d, input logic stopb,
                              input bit toggle_en, input bit clr_on_stop);
        logic b;
        for (int i = 0; i < W + 2; i++) begin
            if (i == 0)          b = 1'b0;
            else if (i == W + 1) b = stopb;
            else                 b = d[W-i];
            en  = 1'b1;
            si  = b;
            clr = (clr_on_stop && i == W + 1);
            step();
            clr = 1'b0;
            if (toggle_en) begin
                en = 1'b0;
                si = 1'($urandom);
                step();
            end
        end
        en = 1'b1;
        si = 1'b1;
    endtask

    task automatic send_rand_frame(input logic [W-1:0] d, input logic stopb);
        logic b;
        bit   sent;
        for (int i = 0; i < W + 2; i++) begin
            if (i == 0)          b = 1'b0;
            else if (i == W + 1) b = stopb;
            else                 b = d[W-i];
            do begin
                en    = ($urandom_range(0, 3) != 0);
                si    = b;
                ready = 1'($urandom);
                clr   = ($urandom_range(0, 15) == 0);
                sent  = en;
                step();
            end while (!sent);
        end
        clr = 1'b0;
        en  = 1'b1;
        si  = 1'b1;
    endtask

    initial begin
        tests = 0; fails = 0; vcount = 0;
        m_q = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_inframe = 1'b0;
        rst = 1'b1; en = 1'b1; si = 1'b1; ready = 1'b0; clr = 1'b0;

        // 1: reset state and idle hold
        step(); step();
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ferr", 32'(ferr), 32'h0);
        chk("rst_ovr", 32'(ovr), 32'h0);
        rst = 1'b0;
        repeat (10) step();
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_valid", 32'(valid), 32'h0);

        // 2: single frame, held until accepted
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        chk("f2_q", 32'(q), 32'hA5);
        chk("f2_valid", 32'(valid), 32'h1);
        chk("f2_busy", 32'(busy), 32'h0);
        repeat (3) step();
        chk("f2_hold_q", 32'(q), 32'hA5);
        chk("f2_hold_valid", 32'(valid), 32'h1);
        ready = 1'b1; step(); ready = 1'b0;
        chk("f2_accept_valid", 32'(valid), 32'h0);

        // 3: back-to-back frames with ready held high
        ready = 1'b1; vcount = 0;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        chk("f3a_q", 32'(q), 32'hA5);
        chk("f3a_valid", 32'(valid), 32'h1);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        chk("f3b_q", 32'(q), 32'h3C);
        chk("f3b_valid", 32'(valid), 32'h1);
        step();
        chk("f3_pulses", 32'(vcount), 32'd2);
        chk("f3_ovr", 32'(ovr), 32'h0);

        // 4: overrun while holding
        ready = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        chk("f4_q", 32'(q), 32'hA5);
        chk("f4_ovr", 32'(ovr), 32'h1);
        clr = 1'b1; step(); clr = 1'b0;
        chk("f4_clr_ovr", 32'(ovr), 32'h0);
        chk("f4_valid", 32'(valid), 32'h1);
        ready = 1'b1; step(); ready = 1'b0;

        // 5: framing error, then clr colliding with a new error
        send_frame(8'h77, 1'b0, 1'b0, 1'b0);
        chk("f5_ferr", 32'(ferr), 32'h1);
        chk("f5_valid", 32'(valid), 32'h0);
        chk("f5_busy", 32'(busy), 32'h0);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        chk("f5_set_wins", 32'(ferr), 32'h1);
        clr = 1'b1; step(); clr = 1'b0;
        chk("f5_clr", 32'(ferr), 32'h0);

        // 6: en toggling each cycle, then reset mid-frame
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        chk("f6_q", 32'(q), 32'h5A);
        chk("f6_valid", 32'(valid), 32'h1);
        en = 1'b1; si = 1'b0; step();
        for (int i = 0; i < 4; i++) begin
            si = 1'($urandom); step();
        end
        chk("f6_mid_busy", 32'(busy), 32'h1);
        rst = 1'b1; si = 1'b1; step(); rst = 1'b0;
        chk("f6_rst_busy", 32'(busy), 32'h0);
        chk("f6_rst_valid", 32'(valid), 32'h0);
        chk("f6_rst_q", 32'(q), 32'h0);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        chk("f6_after_q", 32'(q), 32'hC3);
        chk("f6_after_valid", 32'(valid), 32'h1);

        // Randomized frames, idle gaps, ready, clr and en gaps
        for (int n = 0; n < 200; n++) begin
            send_rand_frame(W'($urandom), ($urandom_range(0, 7) != 0));
            repeat ($urandom_range(0, 2)) begin
                ready = 1'($urandom);
                en    = 1'($urandom);
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
